mips_data_mem_responder: RTL and testbench

- Word-organised data memory: the responder side of the CPU's MEM-stage load/store interface.
- Accepts one request at a time over a valid/ready handshake and performs a read or byte-enabled write after a programmable wait latency.
- Returns a response over a second valid/ready handshake.
- Replaces the fixed-timing RAM so the CPU FSM can stall on memory.

---
 rtl/mips_data_mem_responder_if.sv | 23 ++
 rtl/mips_data_mem_responder.sv | 113 +++++++++++
 tb/tb_mips_data_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_data_mem_responder_if.sv
// Load/store handshake between the CPU MEM stage (master) and the data memory (slave).
interface mips_data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Word-organised data memory answering one load/store at a time after LATENCY wait cycles.
module mips_data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    mips_data_mem_responder_if.slave         bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [3:0]     be_q, be_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           rerr_q, rerr_d;
    logic           do_op;
    logic           req_err;

    logic [31:0]    mem [DEPTH];

    // Upper address bits are never aliased: anything past the last word is rejected.
    assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                     ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        do_op   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    be_d    = bus.req_be;
                    idx_d   = bus.req_addr[IW+1:2];
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    cnt_d   = 4'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    do_op   = 1'b1;
                    rdata_d = (we_q || err_q) ? 32'h0 : mem[idx_q];
                    rerr_d  = err_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage has no reset; an abort by reset_n lands in IDLE so do_op stays low.
    always_ff @(posedge clk) begin
        if (do_op && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = rerr_q;
endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Drives a LATENCY=2 and a LATENCY=0 responder with shared stimulus and checks both against a transaction model.
module tb_mips_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;

    int checks = 0;
    int fails  = 0;
    bit rnd_rr = 1'b0;

    mips_data_mem_responder_if ifa ();
    mips_data_mem_responder_if ifb ();

    assign ifa.req_valid = req_valid;  assign ifb.req_valid = req_valid;
    assign ifa.req_we    = req_we;     assign ifb.req_we    = req_we;
    assign ifa.req_be    = req_be;     assign ifb.req_be    = req_be;
    assign ifa.req_addr  = req_addr;   assign ifb.req_addr  = req_addr;
    assign ifa.req_wdata = req_wdata;  assign ifb.req_wdata = req_wdata;
    assign ifa.resp_ready = resp_ready; assign ifb.resp_ready = resp_ready;

    logic [1:0]  rdy, rv, er;
    logic [31:0] rd [2];
    assign rdy[0] = ifa.req_ready;  assign rdy[1] = ifb.req_ready;
    assign rv[0]  = ifa.resp_valid; assign rv[1]  = ifb.resp_valid;
    assign er[0]  = ifa.resp_err;   assign er[1]  = ifb.resp_err;
    assign rd[0]  = ifa.resp_rdata; assign rd[1]  = ifb.resp_rdata;

    mips_data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    mips_data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d got=%h expected=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Transaction model: a request accepted at edge N answers from edge N+LAT+1 until the handshake edge.
    int unsigned cyc = 0;
    int          lat [2] = '{2, 0};
    bit          mb [2] = '{0, 0};
    bit          mr [2] = '{0, 0};
    bit          merr [2] = '{0, 0};
    bit          mwe [2];
    logic [3:0]  mbe [2];
    logic [31:0] maddr [2], mwd [2];
    logic [31:0] mrd [2] = '{32'h0, 32'h0};
    int unsigned macc [2];
    logic [31:0] mm [2][256];

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                mb[k] = 0; mr[k] = 0; merr[k] = 0; mrd[k] = '0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!mb[k]) begin
                    if (req_valid) begin
                        mb[k] = 1; macc[k] = cyc; mwe[k] = req_we; mbe[k] = req_be;
                        maddr[k] = req_addr; mwd[k] = req_wdata;
                    end
                end else if (!mr[k]) begin
                    if (cyc == macc[k] + lat[k] + 1) begin
                        int unsigned w;
                        logic [31:0] t;
                        mr[k] = 1;
                        w = int'(maddr[k][31:2]);
                        if (maddr[k][1:0] != 2'b00 || maddr[k][31:2] >= 30'd256) begin
                            merr[k] = 1; mrd[k] = '0;
                        end else if (mwe[k]) begin
                            t = mm[k][w];
                            for (int b = 0; b < 4; b++)
                                if (mbe[k][b]) t[8*b +: 8] = mwd[k][8*b +: 8];
                            mm[k][w] = t;
                            merr[k] = 0; mrd[k] = '0;
                        end else begin
                            merr[k] = 0; mrd[k] = mm[k][w];
                        end
                    end
                end else if (resp_ready) begin
                    mb[k] = 0; mr[k] = 0; merr[k] = 0; mrd[k] = '0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("req_ready",  k, {31'b0, rdy[k]}, {31'b0, !mb[k]});
            chk("resp_valid", k, {31'b0, rv[k]},  {31'b0, mr[k]});
            chk("resp_rdata", k, rd[k], mr[k] ? mrd[k] : 32'h0);
            chk("resp_err",   k, {31'b0, er[k]},  {31'b0, mr[k] & merr[k]});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(rdy[0] === 1'b1 && rdy[1] === 1'b1) && n < 200) begin
            if (rnd_rr) resp_ready = ($urandom % 4) != 0;
            @(negedge clk); n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 32'd0, 32'd1);
    endtask

    // Issues one request while both responders are idle; returns what dut_a answered.
    task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                          output int lat_seen);
        int n = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 0; req_we = 1'($urandom); req_be = 4'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        while (rv[0] !== 1'b1 && n < 100) begin
            if (rnd_rr) resp_ready = ($urandom % 4) != 0;
            @(negedge clk); n++;
        end
        if (n >= 100) chk("resp_timeout", 0, 32'd0, 32'd1);
        lat_seen = n;
        rdata = rd[0];
        err = er[0];
        wait_idle();
    endtask

    logic [31:0] pre [16];
    logic [31:0] r, hold_d;
    logic        e;
    int          l, acc_a, acc_b;

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1;
        chk("rst_ready", 0, {31'b0, rdy[0]}, 32'd1);
        chk("rst_valid", 0, {31'b0, rv[0]}, 32'd0);
        chk("rst_rdata", 0, rd[0], 32'h0);
        chk("rst_err",   0, {31'b0, er[0]}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            pre[i] = (i == 8) ? 32'h0 : $urandom;
            do_req(1, 4'hF, 32'(4 * i), pre[i], r, e, l);
        end

        do_req(1, 4'hF, 32'h10, 32'hDEADBEEF, r, e, l);
        chk("st_latency", 0, 32'(l), 32'd3);
        chk("st_rdata", 0, r, 32'h0);
        chk("st_err", 0, {31'b0, e}, 32'd0);
        do_req(0, 4'h0, 32'h10, 32'h0, r, e, l);
        chk("ld_deadbeef", 0, r, 32'hDEADBEEF);

        do_req(1, 4'b0101, 32'h10, 32'h11223344, r, e, l);
        do_req(0, 4'hF, 32'h10, 32'h0, r, e, l);
        chk("ld_merge", 0, r, 32'hDE22BE44);

        do_req(0, 4'h0, 32'h13, 32'h0, r, e, l);
        chk("misalign_err", 0, {31'b0, e}, 32'd1);
        chk("misalign_rdata", 0, r, 32'h0);
        do_req(1, 4'hF, 32'h400, 32'hFFFFFFFF, r, e, l);
        chk("range_err", 0, {31'b0, e}, 32'd1);
        do_req(0, 4'h0, 32'h0, 32'h0, r, e, l);
        chk("word0_kept", 0, r, pre[0]);

        // Response back-pressure with a second request waiting on the bus.
        resp_ready = 0;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_be = 4'hF; req_addr = 32'h10;
        @(negedge clk);
        req_addr = 32'h24;
        l = 0;
        while (rv[0] !== 1'b1 && l < 50) begin @(negedge clk); l++; end
        if (l >= 50) chk("hold_timeout", 0, 32'd0, 32'd1);
        hold_d = rd[0];
        chk("hold_first", 0, hold_d, 32'hDE22BE44);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 0, {31'b0, rv[0]}, 32'd1);
            chk("hold_data",  0, rd[0], hold_d);
            chk("hold_ready", 0, {31'b0, rdy[0]}, 32'd0);
        end
        resp_ready = 1;
        @(negedge clk);
        chk("hs_valid", 0, {31'b0, rv[0]}, 32'd0);
        chk("hs_ready", 0, {31'b0, rdy[0]}, 32'd1);
        @(negedge clk);
        chk("second_accept", 0, {31'b0, rdy[0]}, 32'd0);
        req_valid = 0;
        wait_idle();

        // Reset during WAIT of a store must leave the word untouched.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_be = 4'hF; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        #2 reset_n = 0;
        req_valid = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_ready", k, {31'b0, rdy[k]}, 32'd1);
            chk("abort_valid", k, {31'b0, rv[k]}, 32'd0);
            chk("abort_rdata", k, rd[k], 32'h0);
            chk("abort_err",   k, {31'b0, er[k]}, 32'd0);
        end
        @(negedge clk);
        #2 reset_n = 1;
        do_req(0, 4'h0, 32'h20, 32'h0, r, e, l);
        chk("abort_nowrite", 0, r, 32'h0);

        // Continuous load requests: accepts every LAT+3 cycles.
        wait_idle();
        acc_a = 0; acc_b = 0;
        req_valid = 1; req_we = 0; req_addr = 32'h4;
        for (int s = 0; s < 30; s++) begin
            if (s > 0) @(negedge clk);
            if (rdy[0] === 1'b1) acc_a++;
            if (rdy[1] === 1'b1) acc_b++;
        end
        req_valid = 0;
        chk("b2b_accepts", 0, 32'(acc_a), 32'd6);
        chk("b2b_accepts", 1, 32'(acc_b), 32'd10);
        @(negedge clk);
        wait_idle();

        rnd_rr = 1;
        for (int t = 0; t < 60; t++) begin
            int sel;
            logic [31:0] a;
            sel = $urandom % 10;
            if (sel < 7)       a = 32'(4 * $urandom_range(0, 15));
            else if (sel == 7) a = 32'(4 * $urandom_range(0, 15)) | 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'(4 * $urandom_range(256, 1023));
            else               a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
            do_req(1'($urandom), 4'($urandom), a, $urandom, r, e, l);
        end
        rnd_rr = 0;
        resp_ready = 1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
